mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, maximum consecutive data-port grants while fetch waits; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 if_req  input  1  fetch port requests a read; held until if_gnt.
REQ-005 if_addr  input  32  fetch byte address; stable while if_req=1.
REQ-006 if_flush  input  1  discard the outstanding fetch response (branch/jump redirect).
REQ-007 if_gnt  output  1  fetch request accepted this cycle.
REQ-008 if_rvalid  output  1  one-cycle pulse; if_rdata valid.
REQ-009 if_rdata  output  32  fetched instruction word.
REQ-010 dm_req  input  1  data port requests access; held until dm_gnt.
REQ-011 dm_we  input  1  1 = store, 0 = load.
REQ-012 dm_addr  input  32  data byte address.
REQ-013 dm_wdata  input  32  store data.
REQ-014 dm_gnt  output  1  data request accepted this cycle.
REQ-015 dm_rvalid  output  1  one-cycle pulse; load data valid, or store acknowledged.
REQ-016 dm_rdata  output  32  load data; 0 for stores.
REQ-017 mem_req  output  1  request to the shared memory; held until mem_ready.
REQ-018 mem_we  output  1  write enable to the memory.
REQ-019 mem_addr  output  32  memory address.
REQ-020 mem_wdata  output  32  memory write data.
REQ-021 mem_rdata  input  32  memory read data; valid when mem_ready=1.
REQ-022 mem_ready  input  1  memory completes the current access this cycle.
REQ-023 conflict_cnt  output  32  cycles in IDLE with if_req and dm_req both set.
REQ-024 starve_cnt  output  32  number of forced fetch grants triggered by STARVE_LIMIT.

Function
REQ-025 FSM states: IDLE, BUSY_IF, BUSY_DM, RESP.
REQ-026 IDLE, no request -> stay IDLE; all gnt outputs 0; mem_req 0.
REQ-027 IDLE, one request -> gnt for that port asserted combinationally in that cycle; addr/we/wdata latched; next state BUSY_IF or BUSY_DM.
REQ-028 IDLE, both requests -> dm wins, unless wait_cnt = STARVE_LIMIT, in which case if wins.
REQ-029 wait_cnt is a 4-bit counter: +1 on each dm grant while if_req=1, saturating at STARVE_LIMIT; cleared on each if grant.
REQ-030 Never more than one gnt per cycle; gnt only in IDLE.
REQ-031 BUSY_x: mem_req=1, mem_addr/mem_we/mem_wdata driven from latched registers (mem_we=0 in BUSY_IF); stay until mem_ready=1.
REQ-032 BUSY_x and mem_ready=1 -> capture mem_rdata (0 for stores), next state RESP.
REQ-033 RESP: owner rvalid=1 for exactly one cycle with captured data; next state IDLE; no grant in RESP.
REQ-034 Minimum latency: gnt cycle N, mem_req cycle N+1, mem_ready cycle N+1 -> rvalid cycle N+2; throughput one access per 3 cycles.
REQ-035 if_flush=1 in any cycle of BUSY_IF or RESP owned by fetch (including the mem_ready cycle) sets a drop flag; the memory access still completes; if_rvalid is suppressed; the flag clears on return to IDLE.
REQ-036 if_flush is ignored in IDLE and BUSY_DM.
REQ-037 Data accesses are never dropped.
REQ-038 rdata outputs hold their last value when rvalid=0.

Reset
REQ-039 reset=1 -> state IDLE; wait_cnt, drop flag, and latched registers 0; all gnt, rvalid, and mem_req outputs 0 the next cycle.
REQ-040 Any in-flight access is abandoned without a response.
REQ-041 if_rdata, dm_rdata, and both stats counters reset to 0.
REQ-042 Reset overrides all other inputs in the same cycle.

Configuration
REQ-043 Macro ARB_STATS_EN defined -> conflict_cnt and starve_cnt count as specified; they wrap at 2^32.
REQ-044 ARB_STATS_EN undefined -> both ports are present and tied to 0, and no counter flops are generated.

Verification
REQ-045 Only if_req, addr 0x10; mem_ready is high the cycle after grant -> if_gnt at cycle 0, mem_req at cycle 1, if_rvalid at cycle 2 with mem_rdata 0x00000013.
REQ-046 if_req and dm_req both held continuously, STARVE_LIMIT=4 -> grant order dm, dm, dm, dm, if, dm...; starve_cnt=1 after the fifth grant (with ARB_STATS_EN).
REQ-047 Store dm_addr 0x100, wdata 0xDEADBEEF, mem_ready delayed 3 cycles -> mem_req held 4 cycles with mem_we=1; dm_rvalid pulse with dm_rdata=0.
REQ-048 Fetch in BUSY_IF with if_flush pulsed together with mem_ready -> no if_rvalid; next if grant is accepted 2 cycles later.
REQ-049 reset asserted during BUSY_DM -> mem_req=0 and state IDLE next cycle; no dm_rvalid ever issued.
REQ-050 Both requests for 10 cycles, ARB_STATS_EN undefined -> conflict_cnt and starve_cnt stay 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, data port and shared-memory bus of mem_port_arbiter.
// The master modport is the arbiter's view; the slave modport is the surrounding system's view.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        input  if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata,
               mem_rdata, mem_ready,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata,
               mem_rdata, mem_ready,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto one shared memory, data-priority with a starvation bound for fetch.
// Optional statistics counters are built only when ARB_STATS_EN is defined.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.master  bus,
    output logic [31:0]         conflict_cnt,
    output logic [31:0]         starve_cnt
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_r, state_s;
    logic [3:0]  wait_r;
    logic        drop_r;
    logic        owner_dm_r;
    logic        we_r;
    logic [31:0] addr_r, wdata_r, cap_r;
    logic [31:0] if_hold_r, dm_hold_r;
    logic        if_gnt_s, dm_gnt_s, mem_req_s, if_rvalid_s, dm_rvalid_s;
    logic        starve_hit_s;

    assign starve_hit_s = bus.if_req && (wait_r == LIMIT);

    // Next-state, grant and response decode
    always_comb begin
        state_s     = state_r;
        if_gnt_s    = 1'b0;
        dm_gnt_s    = 1'b0;
        mem_req_s   = 1'b0;
        if_rvalid_s = 1'b0;
        dm_rvalid_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (reset) begin
                    state_s = IDLE;
                end else if (bus.dm_req && !starve_hit_s) begin
                    dm_gnt_s = 1'b1;
                    state_s  = BUSY_DM;
                end else if (bus.if_req) begin
                    if_gnt_s = 1'b1;
                    state_s  = BUSY_IF;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY_IF, BUSY_DM: begin
                mem_req_s = 1'b1;
                if (bus.mem_ready) begin
                    state_s = RESP;
                end else begin
                    state_s = state_r;
                end
            end
            RESP: begin
                state_s = IDLE;
                if (owner_dm_r) begin
                    dm_rvalid_s = 1'b1;
                end else begin
                    // A flush arriving in the response cycle itself still kills the fetch data.
                    if_rvalid_s = !drop_r && !bus.if_flush;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, request latches, starvation counter, drop flag and response data
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            wait_r     <= 4'd0;
            drop_r     <= 1'b0;
            owner_dm_r <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= 32'd0;
            wdata_r    <= 32'd0;
            cap_r      <= 32'd0;
            if_hold_r  <= 32'd0;
            dm_hold_r  <= 32'd0;
        end else begin
            state_r <= state_s;
            if (if_gnt_s) begin
                owner_dm_r <= 1'b0;
                we_r       <= 1'b0;
                addr_r     <= bus.if_addr;
                wdata_r    <= 32'd0;
                wait_r     <= 4'd0;
            end else if (dm_gnt_s) begin
                owner_dm_r <= 1'b1;
                we_r       <= bus.dm_we;
                addr_r     <= bus.dm_addr;
                wdata_r    <= bus.dm_wdata;
                if (bus.if_req && (wait_r < LIMIT)) begin
                    wait_r <= wait_r + 4'd1;
                end
            end
            if (state_r == RESP) begin
                drop_r <= 1'b0;
            end else if ((state_r == BUSY_IF) && bus.if_flush) begin
                drop_r <= 1'b1;
            end
            if (mem_req_s && bus.mem_ready) begin
                cap_r <= we_r ? 32'd0 : bus.mem_rdata;
            end
            if (if_rvalid_s) begin
                if_hold_r <= cap_r;
            end
            if (dm_rvalid_s) begin
                dm_hold_r <= cap_r;
            end
        end
    end

    assign bus.if_gnt    = if_gnt_s;
    assign bus.dm_gnt    = dm_gnt_s;
    assign bus.if_rvalid = if_rvalid_s;
    assign bus.dm_rvalid = dm_rvalid_s;
    assign bus.if_rdata  = if_rvalid_s ? cap_r : if_hold_r;
    assign bus.dm_rdata  = dm_rvalid_s ? cap_r : dm_hold_r;
    assign bus.mem_req   = mem_req_s;
    assign bus.mem_we    = we_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;

`ifdef ARB_STATS_EN
    logic [31:0] conflict_r, starve_r;

    // Contention statistics, sampled only while arbitrating
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_r <= 32'd0;
            starve_r   <= 32'd0;
        end else if ((state_r == IDLE) && bus.if_req && bus.dm_req) begin
            conflict_r <= conflict_r + 32'd1;
            if (wait_r == LIMIT) begin
                starve_r <= starve_r + 32'd1;
            end
        end
    end

    assign conflict_cnt = conflict_r;
    assign starve_cnt   = starve_r;
`else
    assign conflict_cnt = 32'd0;
    assign starve_cnt   = 32'd0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level reference model checked every cycle,
// plus literal expectations for latency, grant order, store, flush and reset scenarios.
module tb_mem_port_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] conflict_cnt, starve_cnt;
    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) u_dut (
        .clk(clk), .reset(reset), .bus(bus),
        .conflict_cnt(conflict_cnt), .starve_cnt(starve_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a == 32'h10) ? 32'h13 : {a[15:0], 16'hA5A5};
    endfunction

    // Memory responder: ready after 'lat' wait cycles of mem_req
    int lat = 0;
    int req_cycles = 0;
    bit flush_on_ready = 1'b0;
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.mem_req) begin
                if (req_cycles >= lat) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = rd_fn(bus.mem_addr);
                end else begin
                    bus.mem_ready = 1'b0;
                end
                req_cycles++;
            end else begin
                req_cycles = 0;
                bus.mem_ready = 1'b0;
            end
            if (flush_on_ready) bus.if_flush = bus.mem_ready;
        end
    end

    // Reference model: one outstanding transaction, described by phase 0=free, 1=at memory, 2=responding
    int          m_phase = 0;
    int          m_wait = 0;
    bit          m_own_dm = 1'b0, m_we = 1'b0, m_drop = 1'b0;
    logic [31:0] m_addr = 32'd0, m_wdata = 32'd0, m_cap = 32'd0;
    logic [31:0] m_ifhold = 32'd0, m_dmhold = 32'd0, m_conf = 32'd0, m_starve = 32'd0;

    int          t_if_gnt = 0, t_mem_rise = 0, t_if_rv = 0, t_ready = 0;
    int          n_if_rv = 0, n_dm_rv = 0, run_len = 0, last_run = 0;
    bit          run_we = 1'b1, last_run_we = 1'b0, prev_req = 1'b0;
    logic [31:0] last_ifr = 32'd0, last_dmr = 32'd0, run_addr = 32'd0;
    bit          glog[$];

    initial begin
        bit          e_ig, e_dg, e_ir, e_dr;
        logic [31:0] e_ird, e_drd;
        forever begin
            @(negedge clk);
            e_ig = 1'b0;
            e_dg = 1'b0;
            if (!reset && m_phase == 0) begin
                if (bus.if_req && bus.dm_req) begin
                    if (m_wait == LIMIT) e_ig = 1'b1; else e_dg = 1'b1;
                end else if (bus.dm_req) e_dg = 1'b1;
                else if (bus.if_req) e_ig = 1'b1;
            end
            e_ir  = (m_phase == 2) && !m_own_dm && !m_drop && !bus.if_flush;
            e_dr  = (m_phase == 2) && m_own_dm;
            e_ird = e_ir ? m_cap : m_ifhold;
            e_drd = e_dr ? m_cap : m_dmhold;

            chk("if_gnt", {31'd0, bus.if_gnt}, {31'd0, e_ig});
            chk("dm_gnt", {31'd0, bus.dm_gnt}, {31'd0, e_dg});
            chk("mem_req", {31'd0, bus.mem_req}, {31'd0, m_phase == 1});
            chk("if_rvalid", {31'd0, bus.if_rvalid}, {31'd0, e_ir});
            chk("dm_rvalid", {31'd0, bus.dm_rvalid}, {31'd0, e_dr});
            chk("if_rdata", bus.if_rdata, e_ird);
            chk("dm_rdata", bus.dm_rdata, e_drd);
            if (m_phase == 1) begin
                chk("mem_addr", bus.mem_addr, m_addr);
                chk("mem_we", {31'd0, bus.mem_we}, {31'd0, m_we});
                if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
            end
`ifdef ARB_STATS_EN
            chk("conflict_cnt", conflict_cnt, m_conf);
            chk("starve_cnt", starve_cnt, m_starve);
`else
            chk("conflict_cnt", conflict_cnt, 32'd0);
            chk("starve_cnt", starve_cnt, 32'd0);
`endif
            // Event log for the directed scenario checks
            if (bus.if_gnt) begin t_if_gnt = cyc; glog.push_back(1'b0); end
            if (bus.dm_gnt) glog.push_back(1'b1);
            if (bus.mem_req && !prev_req) begin t_mem_rise = cyc; run_len = 0; run_we = 1'b1; run_addr = bus.mem_addr; end
            if (bus.mem_req) begin run_len++; run_we = run_we && bus.mem_we; end
            if (!bus.mem_req && prev_req) begin last_run = run_len; last_run_we = run_we; end
            if (bus.mem_req && bus.mem_ready) t_ready = cyc;
            if (bus.if_rvalid) begin t_if_rv = cyc; n_if_rv++; last_ifr = bus.if_rdata; end
            if (bus.dm_rvalid) begin n_dm_rv++; last_dmr = bus.dm_rdata; end
            prev_req = bus.mem_req;

            if (reset) begin
                m_phase = 0; m_wait = 0; m_drop = 1'b0; m_own_dm = 1'b0; m_we = 1'b0;
                m_addr = 32'd0; m_wdata = 32'd0; m_cap = 32'd0;
                m_ifhold = 32'd0; m_dmhold = 32'd0; m_conf = 32'd0; m_starve = 32'd0;
            end else if (m_phase == 0) begin
                if (bus.if_req && bus.dm_req) begin
                    m_conf++;
                    if (m_wait == LIMIT) m_starve++;
                end
                if (e_ig) begin
                    m_phase = 1; m_own_dm = 1'b0; m_we = 1'b0; m_addr = bus.if_addr; m_wdata = 32'd0; m_wait = 0;
                end else if (e_dg) begin
                    m_phase = 1; m_own_dm = 1'b1; m_we = bus.dm_we; m_addr = bus.dm_addr; m_wdata = bus.dm_wdata;
                    if (bus.if_req && m_wait < LIMIT) m_wait++;
                end
            end else if (m_phase == 1) begin
                if (!m_own_dm && bus.if_flush) m_drop = 1'b1;
                if (bus.mem_ready) begin
                    m_cap = m_we ? 32'd0 : bus.mem_rdata;
                    m_phase = 2;
                end
            end else begin
                if (e_ir) m_ifhold = m_cap;
                if (e_dr) m_dmhold = m_cap;
                m_drop = 1'b0;
                m_phase = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input bit dm);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (dm ? bus.dm_gnt : bus.if_gnt) return;
        end
        checks++;
        errors++;
        $display("FAIL gnt_timeout: got no grant expected grant within 40 cycles (dm=%0d)", dm);
    endtask

    bit exp_order [6];
    int n0;

    initial begin
        reset = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = 32'd0; bus.if_flush = 1'b0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 32'd0; bus.dm_wdata = 32'd0;
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tick(2);
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'd0);
        chk("rst_dm_rdata", bus.dm_rdata, 32'd0);
        reset = 1'b0;
        tick(2);

        // Single fetch at minimum latency
        lat = 0;
        bus.if_addr = 32'h10; bus.if_req = 1'b1;
        wait_gnt(1'b0);
        tick(1); bus.if_req = 1'b0;
        tick(4);
        chk("lat_mem_req", t_mem_rise - t_if_gnt, 32'd1);
        chk("lat_if_rvalid", t_if_rv - t_if_gnt, 32'd2);
        chk("fetch_data", last_ifr, 32'h13);

        // Continuous contention: starvation bound forces the fifth grant to fetch
        glog.delete();
        bus.if_addr = 32'h20; bus.if_req = 1'b1;
        bus.dm_addr = 32'h200; bus.dm_we = 1'b0; bus.dm_req = 1'b1;
        tick(18);
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
        chk("grant_count", glog.size(), 32'd6);
        for (int i = 0; i < 6 && i < glog.size(); i++)
            chk($sformatf("grant_order_%0d", i), {31'd0, glog[i]}, {31'd0, exp_order[i]});
`ifdef ARB_STATS_EN
        chk("starve_after_5", starve_cnt, 32'd1);
        chk("conflict_after_6", conflict_cnt, 32'd6);
`endif
        tick(6);

        // Store with three wait cycles
        lat = 3;
        n0 = n_dm_rv;
        bus.dm_addr = 32'h100; bus.dm_wdata = 32'hDEADBEEF; bus.dm_we = 1'b1; bus.dm_req = 1'b1;
        wait_gnt(1'b1);
        tick(1); bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        tick(8);
        chk("store_req_len", last_run, 32'd4);
        chk("store_we_held", {31'd0, last_run_we}, 32'd1);
        chk("store_addr", run_addr, 32'h100);
        chk("store_rvalid_cnt", n_dm_rv - n0, 32'd1);
        chk("store_rdata", last_dmr, 32'd0);

        // Flush coinciding with mem_ready drops the fetch; the next fetch follows two cycles later
        lat = 2;
        flush_on_ready = 1'b1;
        n0 = n_if_rv;
        bus.if_addr = 32'h30; bus.if_req = 1'b1;
        wait_gnt(1'b0);
        tick(1); bus.if_addr = 32'h40;
        wait_gnt(1'b0);
        chk("flush_regrant_gap", cyc - t_ready, 32'd2);
        flush_on_ready = 1'b0;
        tick(1); bus.if_req = 1'b0;
        chk("flush_suppressed", n_if_rv - n0, 32'd0);
        tick(8);
        chk("post_flush_fetch", n_if_rv - n0, 32'd1);
        chk("post_flush_data", last_ifr, 32'h0040A5A5);

        // Reset while a load is at memory
        lat = 6;
        n0 = n_dm_rv;
        bus.dm_addr = 32'h300; bus.dm_req = 1'b1;
        wait_gnt(1'b1);
        tick(1); bus.dm_req = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_mem_req", {31'd0, bus.mem_req}, 32'd0);
        tick(10);
        chk("reset_no_rvalid", n_dm_rv - n0, 32'd0);
        chk("reset_dm_rdata", bus.dm_rdata, 32'd0);

        // Ten cycles of contention after reset
        lat = 0;
        bus.if_addr = 32'h50; bus.if_req = 1'b1;
        bus.dm_addr = 32'h500; bus.dm_req = 1'b1;
        tick(10);
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
`ifdef ARB_STATS_EN
        chk("conflict_10", conflict_cnt, 32'd4);
        chk("starve_10", starve_cnt, 32'd0);
`else
        chk("conflict_10", conflict_cnt, 32'd0);
        chk("starve_10", starve_cnt, 32'd0);
`endif
        tick(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
